laser_hit_judge: RTL and testbench

- Parametrised successor to the single-laser player hit check: evaluates N boss lasers against the player hitbox once per frame.
- Adds per-laser warm-up (a beam is harmless until it has been on for WARMUP frames), post-hit invulnerability frames, a lives counter and game-over/revive handling.
- Sits between the boss/laser controller and the game-state/display logic.
- Runs on the system clock, gated by a frame tick.

---
 rtl/laser_hit_judge.sv | 149 ++++++++++++++
 tb/tb_laser_hit_judge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_hit_judge.sv
// Checks N boss lasers against the player hitbox once per frame.
// Tracks beam warm-up, lives and invulnerability, and handles game over and revive.
module laser_hit_judge #(
  parameter int N_LASERS = 4,
  parameter int COORD_W  = 10,
  parameter int HALF_W   = 30,
  parameter int HB_R     = 2,
  parameter int WARMUP   = 8,
  parameter int IFRAMES  = 60,
  parameter int LIVES    = 3,
  parameter int LIFE_W   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic [N_LASERS-1:0]           laser_on,
  input  logic [N_LASERS*COORD_W-1:0]   laser_x,
  input  logic [N_LASERS*COORD_W-1:0]   laser_y,
  input  logic [COORD_W-1:0]            player_x,
  input  logic [COORD_W-1:0]            player_y,
  input  logic                          revive,
  output logic                          hit,
  output logic [N_LASERS-1:0]           hit_mask,
  output logic                          invuln,
  output logic [LIFE_W-1:0]             lives,
  output logic                          game_over
);

  localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int TMR_W = $clog2(IFRAMES + 1);
  localparam int SW    = COORD_W + 2;
  localparam logic signed [SW-1:0] X_REACH = SW'(HALF_W + HB_R);
  localparam logic signed [SW-1:0] Y_REACH = SW'(HB_R);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [LIFE_W-1:0]     lives_q, lives_d;
  logic [N_LASERS-1:0]   hit_mask_q, hit_mask_d;
  logic                  hit_q, hit_d;
  logic                  invuln_q, invuln_d;
  logic                  game_over_q, game_over_d;
  logic [CNT_W-1:0]      warm_q [N_LASERS];
  logic [CNT_W-1:0]      warm_d [N_LASERS];

  logic [N_LASERS-1:0]   armed;
  logic [N_LASERS-1:0]   overlap;
  logic [N_LASERS-1:0]   lethal;
  logic signed [SW-1:0]  px, py;

  assign px = $signed({2'b00, player_x});
  assign py = $signed({2'b00, player_y});

  // Two extra bits keep the difference signed, so a beam near x=0 cannot wrap into a miss.
  for (genvar g = 0; g < N_LASERS; g++) begin : g_ch
    logic signed [SW-1:0] lx, ly, dx, adx;
    assign lx          = $signed({2'b00, laser_x[g*COORD_W +: COORD_W]});
    assign ly          = $signed({2'b00, laser_y[g*COORD_W +: COORD_W]});
    assign dx          = px - lx;
    assign adx         = (dx < 0) ? -dx : dx;
    assign overlap[g]  = (adx <= X_REACH) && ((py + Y_REACH) >= ly);
    assign armed[g]    = laser_on[g] && (warm_q[g] == CNT_W'(WARMUP));
  end

  assign lethal = armed & overlap;

  always_comb begin
    for (int i = 0; i < N_LASERS; i++) begin
      warm_d[i] = warm_q[i];
      if (!laser_on[i]) begin
        warm_d[i] = '0;
      end else if (frame_tick && (warm_q[i] != CNT_W'(WARMUP))) begin
        warm_d[i] = warm_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    lives_d    = lives_q;
    hit_mask_d = hit_mask_q;
    hit_d      = 1'b0;
    if (frame_tick) begin
      case (state_q)
        ALIVE: begin
          if (|lethal) begin
            hit_d      = 1'b1;
            hit_mask_d = lethal;
            lives_d    = lives_q - LIFE_W'(1);
            if (lives_q == LIFE_W'(1)) begin
              state_d = DEAD;
            end else begin
              state_d = INVULN;
              timer_d = TMR_W'(IFRAMES);
            end
          end
        end
        INVULN: begin
          timer_d = timer_q - TMR_W'(1);
          if (timer_q == TMR_W'(1)) begin
            state_d = ALIVE;
          end
        end
        DEAD: begin
          if (revive) begin
            lives_d    = LIFE_W'(LIVES);
            timer_d    = TMR_W'(IFRAMES);
            hit_mask_d = '0;
            state_d    = INVULN;
          end
        end
        default: state_d = ALIVE;
      endcase
    end
    invuln_d    = (state_d == INVULN);
    game_over_d = (state_d == DEAD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ALIVE;
      timer_q     <= '0;
      lives_q     <= LIFE_W'(LIVES);
      hit_mask_q  <= '0;
      hit_q       <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
      for (int i = 0; i < N_LASERS; i++) warm_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lives_q     <= lives_d;
      hit_mask_q  <= hit_mask_d;
      hit_q       <= hit_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
      for (int i = 0; i < N_LASERS; i++) warm_q[i] <= warm_d[i];
    end
  end

  assign hit       = hit_q;
  assign hit_mask  = hit_mask_q;
  assign invuln    = invuln_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_laser_hit_judge.sv
// Bench for laser_hit_judge: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a frame-level game model.
module tb_laser_hit_judge;

  localparam int N       = 4;
  localparam int W       = 10;
  localparam int HALF_W  = 30;
  localparam int HB_R    = 2;
  localparam int WARMUP  = 8;
  localparam int IFRAMES = 60;
  localparam int LIVES   = 3;
  localparam int LIFE_W  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_tick = 1'b0;
  logic [N-1:0]     laser_on = '0;
  logic [N*W-1:0]   laser_x = '0;
  logic [N*W-1:0]   laser_y = '0;
  logic [W-1:0]     player_x = '0;
  logic [W-1:0]     player_y = '0;
  logic             revive = 1'b0;
  logic             hit;
  logic [N-1:0]     hit_mask;
  logic             invuln;
  logic [LIFE_W-1:0] lives;
  logic             game_over;

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit cmp_en    = 1'b0;

  laser_hit_judge #(
    .N_LASERS(N), .COORD_W(W), .HALF_W(HALF_W), .HB_R(HB_R), .WARMUP(WARMUP),
    .IFRAMES(IFRAMES), .LIVES(LIVES), .LIFE_W(LIFE_W)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .laser_on(laser_on),
    .laser_x(laser_x), .laser_y(laser_y), .player_x(player_x), .player_y(player_y),
    .revive(revive), .hit(hit), .hit_mask(hit_mask), .invuln(invuln),
    .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Game model: mode 0 = playing, 1 = shielded, 2 = dead; warm holds frames seen lit.
  int m_warm [N];
  int m_mode, m_shield, m_lives, m_hit, m_mask, m_lethal;
  int m_lx, m_ly, m_px, m_py;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) m_warm[i] = 0;
      m_mode = 0; m_shield = 0; m_lives = LIVES; m_hit = 0; m_mask = 0;
    end else begin
      m_hit = 0;
      m_lethal = 0;
      m_px = int'(player_x);
      m_py = int'(player_y);
      for (int i = 0; i < N; i++) begin
        m_lx = int'(laser_x[i*W +: W]);
        m_ly = int'(laser_y[i*W +: W]);
        if (laser_on[i] && m_warm[i] >= WARMUP &&
            ((m_px > m_lx) ? m_px - m_lx : m_lx - m_px) <= HALF_W + HB_R &&
            m_py + HB_R >= m_ly)
          m_lethal += (1 << i);
      end
      for (int i = 0; i < N; i++) begin
        if (!laser_on[i]) m_warm[i] = 0;
        else if (frame_tick && m_warm[i] < WARMUP) m_warm[i] += 1;
      end
      if (frame_tick) begin
        if (m_mode == 0 && m_lethal != 0) begin
          m_hit = 1;
          m_mask = m_lethal;
          m_lives -= 1;
          if (m_lives == 0) m_mode = 2;
          else begin m_mode = 1; m_shield = IFRAMES; end
        end else if (m_mode == 1) begin
          m_shield -= 1;
          if (m_shield == 0) m_mode = 0;
        end else if (m_mode == 2 && revive) begin
          m_lives = LIVES; m_shield = IFRAMES; m_mask = 0; m_mode = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_hit", int'(hit), m_hit);
      checkOutput("cyc_mask", int'(hit_mask), m_mask);
      checkOutput("cyc_lives", int'(lives), m_lives);
      checkOutput("cyc_invuln", int'(invuln), int'(m_mode == 1));
      checkOutput("cyc_game_over", int'(game_over), int'(m_mode == 2));
    end
  end

  // Issues back-to-back frame ticks; returns 1 time unit after the last sampled edge.
  task automatic applyStimulus(input int ticks);
    for (int k = 0; k < ticks; k++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic setLaser(input int i, input bit on, input int x, input int y);
    laser_on[i] = on;
    laser_x[i*W +: W] = W'(x);
    laser_y[i*W +: W] = W'(y);
  endtask

  initial begin
    @(posedge clk); #1;
    doReset();
    cmp_en = 1'b1;
    checkOutput("reset_lives", int'(lives), 3);
    checkOutput("reset_hit", int'(hit), 0);
    checkOutput("reset_invuln", int'(invuln), 0);
    checkOutput("reset_game_over", int'(game_over), 0);

    // Warm-up gating: harmless for 8 ticks, lethal on the 9th.
    setLaser(0, 1, 100, 50);
    player_x = 100; player_y = 300;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1);
      checkOutput("warm_nohit", int'(hit), 0);
    end
    applyStimulus(1);
    checkOutput("warm_hit", int'(hit), 1);
    checkOutput("warm_mask", int'(hit_mask), 4'b0001);
    checkOutput("warm_lives", int'(lives), 2);
    checkOutput("warm_invuln", int'(invuln), 1);
    @(posedge clk); #1;
    checkOutput("hit_pulse_once", int'(hit), 0);

    // Horizontal reach boundary.
    doReset();
    player_x = 133; player_y = 0;
    applyStimulus(8);
    player_y = 300;
    applyStimulus(1);
    checkOutput("edge_x133_miss", int'(hit), 0);
    player_x = 132;
    applyStimulus(1);
    checkOutput("edge_x132_hit", int'(hit), 1);

    // Near x=0 the distance must not wrap.
    doReset();
    setLaser(0, 1, 10, 50);
    player_x = 0; player_y = 0;
    applyStimulus(8);
    player_y = 300;
    applyStimulus(1);
    checkOutput("edge_x0_hit", int'(hit), 1);

    // Vertical boundary: hitbox bottom must reach the beam source.
    doReset();
    setLaser(0, 1, 100, 50);
    player_x = 100; player_y = 47;
    applyStimulus(9);
    checkOutput("edge_y47_miss", int'(hit), 0);
    player_y = 48;
    applyStimulus(1);
    checkOutput("edge_y48_hit", int'(hit), 1);

    // Two lasers on the same tick cost a single life, then 60 shielded frames.
    doReset();
    setLaser(0, 0, 0, 0);
    setLaser(1, 1, 100, 50);
    setLaser(3, 1, 100, 50);
    player_x = 100; player_y = 0;
    applyStimulus(8);
    player_y = 300;
    applyStimulus(1);
    checkOutput("multi_hit", int'(hit), 1);
    checkOutput("multi_mask", int'(hit_mask), 4'b1010);
    checkOutput("multi_lives", int'(lives), 2);
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1);
      checkOutput("iframe_nohit", int'(hit), 0);
    end
    checkOutput("iframe_over", int'(invuln), 0);
    applyStimulus(1);
    checkOutput("tick61_hit", int'(hit), 1);
    checkOutput("tick61_lives", int'(lives), 1);
    applyStimulus(61);
    checkOutput("third_lives", int'(lives), 0);
    checkOutput("third_game_over", int'(game_over), 1);
    applyStimulus(5);
    checkOutput("dead_nohit", int'(hit), 0);
    checkOutput("dead_lives", int'(lives), 0);

    revive = 1'b1;
    applyStimulus(1);
    revive = 1'b0;
    checkOutput("revive_lives", int'(lives), 3);
    checkOutput("revive_invuln", int'(invuln), 1);
    checkOutput("revive_game_over", int'(game_over), 0);
    checkOutput("revive_mask", int'(hit_mask), 0);

    // Reset in the middle of the shield window; the beam must warm up again.
    applyStimulus(30);
    doReset();
    checkOutput("midreset_lives", int'(lives), 3);
    checkOutput("midreset_invuln", int'(invuln), 0);
    checkOutput("midreset_mask", int'(hit_mask), 0);
    applyStimulus(8);
    checkOutput("rewarm_nohit", int'(hit), 0);
    applyStimulus(1);
    checkOutput("rewarm_hit", int'(hit), 1);

    // Randomized play checked by the per-cycle compare process.
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 599) != 0);
      frame_tick = $urandom_range(0, 1) != 0;
      revive     = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 29) == 0) laser_on[i] = ~laser_on[i];
        if ($urandom_range(0, 49) == 0)
          setLaser(i, laser_on[i], $urandom_range(70, 130), $urandom_range(0, 300));
      end
      if ($urandom_range(0, 9) == 0) player_x = W'($urandom_range(60, 140));
      if ($urandom_range(0, 9) == 0) player_y = W'($urandom_range(0, 400));
      if ($urandom_range(0, 199) == 0) player_x = W'($urandom_range(0, 20));
      @(posedge clk); #1;
    end
    rst = 1'b1; frame_tick = 1'b0; revive = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
